// File: rtl/lut_m_ram.sv
// lut_m_ram: M-slice memory LUT, chunked config chain, ROM/RAM/SRL/FRAC write modes.
// Define LUT_M_OUT_REG_EN to register out/out2 (1-cycle read latency).
module lut_m_ram #(
  parameter int INPUTS = 4,
  parameter int MEM_SIZE = 2**INPUTS,
  parameter int CONFIG_WIDTH = 4
) (
  input  logic                    cclk,
  input  logic                    rst_n,
  input  logic [INPUTS-1:0]       addr,
  output logic                    out,
  output logic                    out2,
  input  logic [INPUTS-1:0]       waddr,
  input  logic                    data_in,
  input  logic                    write_en,
  input  logic [1:0]              mode,
  input  logic                    cen,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    cfg_done
);
  localparam int NCH = MEM_SIZE / CONFIG_WIDTH;
  localparam int CW = $clog2(NCH + 1);
  localparam logic [CW-1:0] NCH_V = CW'(NCH);
  logic [MEM_SIZE-1:0] mem;
  logic [CW-1:0] cfg_cnt;
  logic [INPUTS-2:0] lo;
  logic frac, out_c, out2_c;
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      mem <= '0;
      cfg_cnt <= '0;
    end else if (cen) begin
      mem <= {config_in, mem[MEM_SIZE-1:CONFIG_WIDTH]};
      cfg_cnt <= (cfg_cnt == NCH_V) ? cfg_cnt : cfg_cnt + 1'b1;
    end else if (write_en && mode == 2'b10) mem <= {mem[MEM_SIZE-2:0], data_in};
    else if (write_en && mode[0]) mem[waddr] <= data_in;
  assign cfg_done = cfg_cnt == NCH_V;
  assign config_out = mem[CONFIG_WIDTH-1:0];
  // FRAC splits the table into two halves sharing the low address bits
  assign lo = addr[INPUTS-2:0];
  assign frac = mode == 2'b11;
  assign out_c = frac ? mem[{1'b0, lo}] : mem[addr];
  assign out2_c = frac & mem[{1'b1, lo}];
`ifdef LUT_M_OUT_REG_EN
  logic out_q, out2_q;
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      out_q <= 1'b0;
      out2_q <= 1'b0;
    end else begin
      out_q <= out_c;
      out2_q <= out2_c;
    end
  assign out = out_q;
  assign out2 = out2_q;
`else
  assign out = out_c;
  assign out2 = out2_c;
`endif
endmodule
